// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared MIPS decode constants, hazard FSM states and instruction field helpers
// used by the hazard controller and the forwarding unit.
package hazard_stall_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_COP0  = 6'b010000;

  localparam logic [4:0] RS_MFC0  = 5'b00000;
  localparam logic [4:0] RS_MTC0  = 5'b00100;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    MEM_WAIT  = 2'd2,
    EXC_FLUSH = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;
    logic stall_active;
  } hz_ctrl_t;

  function automatic logic [5:0] op_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] instr);
    return instr[20:16];
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-register view and hazard control outputs exchanged between the
// MIPS datapath (master) and the hazard controller (slave).
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [63:0]      ifid_reg;
  logic [159:0]     idex_reg;
  logic             branch_taken;
  logic             exc_req;
  logic             mem_ready;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             idex_write_en;
  logic             exmem_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_flush;
  logic             stall_active;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ifid_reg, idex_reg, branch_taken, exc_req, mem_ready,
    input  pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
           ifid_flush, idex_bubble, exmem_flush, stall_active, stall_cycles
  );

  modport slave (
    input  ifid_reg, idex_reg, branch_taken, exc_req, mem_ready,
    output pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
           ifid_flush, idex_bubble, exmem_flush, stall_active, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl_decode.sv
// Combinational classifier for one pipeline-register instruction: load
// producer with its destination, and which source registers it reads.
module hazard_stall_ctrl_decode
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_load,
  output logic [4:0]  dst,
  output logic        reads_rs,
  output logic        reads_rt
);

  logic [5:0] op;
  logic [4:0] rs;

  assign op  = op_of(instr);
  assign rs  = rs_of(instr);
  assign dst = rt_of(instr);

  // COP0 reuses the rs field as a sub-opcode, so it never reads rs as a GPR.
  always_comb begin
    is_load  = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               ((op == OP_COP0) && (rs == RS_MFC0));
    reads_rs = (op != OP_J) && (op != OP_JAL) && (op != OP_COP0);
    reads_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_SB) ||
               ((op == OP_COP0) && (rs == RS_MTC0));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use bubbles, memory
// freeze, branch/exception flushes and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_stall_ctrl_if.slave bus
);

  hz_state_t        state;
  hz_state_t        mode;
  hz_ctrl_t         ctrl;
  logic [CNT_W-1:0] cnt;

  logic       ex_is_load;
  logic [4:0] ex_dst;
  logic       ex_reads_rs;
  logic       ex_reads_rt;
  logic       id_is_load;
  logic [4:0] id_dst;
  logic       id_reads_rs;
  logic       id_reads_rt;
  logic       load_use;
  logic [31:0] id_instr;

  assign id_instr = bus.ifid_reg[31:0];

  hazard_stall_ctrl_decode u_dec_ex (
    .instr    (bus.idex_reg[31:0]),
    .is_load  (ex_is_load),
    .dst      (ex_dst),
    .reads_rs (ex_reads_rs),
    .reads_rt (ex_reads_rt)
  );

  hazard_stall_ctrl_decode u_dec_id (
    .instr    (id_instr),
    .is_load  (id_is_load),
    .dst      (id_dst),
    .reads_rs (id_reads_rs),
    .reads_rt (id_reads_rt)
  );

  always_comb begin
    load_use = ex_is_load && (ex_dst != 5'd0) &&
               ((id_reads_rs && (rs_of(id_instr) == ex_dst)) ||
                (id_reads_rt && (rt_of(id_instr) == ex_dst)));
  end

  // mode is the state being occupied this cycle; outputs decode from it so
  // every hazard reacts with zero latency. A stall already served is not repeated.
  always_comb begin
    mode = RUN;
    if (bus.exc_req)
      mode = EXC_FLUSH;
    else if (!bus.mem_ready)
      mode = MEM_WAIT;
    else if (load_use && (state != LU_STALL))
      mode = LU_STALL;
  end

  always_comb begin
    ctrl = '0;
    case (mode)
      EXC_FLUSH: ctrl = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
                          ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_flush: 1'b1,
                          stall_active: 1'b0};
      MEM_WAIT:  ctrl = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0, exmem_we: 1'b0,
                          ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_flush: 1'b0,
                          stall_active: 1'b1};
      LU_STALL:  ctrl = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1, exmem_we: 1'b1,
                          ifid_flush: 1'b0, idex_bubble: 1'b1, exmem_flush: 1'b0,
                          stall_active: 1'b1};
      default:   ctrl = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
                          ifid_flush: bus.branch_taken, idex_bubble: 1'b0,
                          exmem_flush: 1'b0, stall_active: 1'b0};
    endcase
    if (!rst_n)
      ctrl = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0, exmem_we: 1'b0,
               ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_flush: 1'b1,
               stall_active: 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= mode;
      if (ctrl.stall_active && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.pc_write_en    = ctrl.pc_we;
  assign bus.ifid_write_en  = ctrl.ifid_we;
  assign bus.idex_write_en  = ctrl.idex_we;
  assign bus.exmem_write_en = ctrl.exmem_we;
  assign bus.ifid_flush     = ctrl.ifid_flush;
  assign bus.idex_bubble    = ctrl.idex_bubble;
  assign bus.exmem_flush    = ctrl.exmem_flush;
  assign bus.stall_active   = ctrl.stall_active;
  assign bus.stall_cycles   = cnt;

  logic unused_bits;
  assign unused_bits = ^{bus.ifid_reg[63:32], bus.idex_reg[159:32],
                         ex_reads_rs, ex_reads_rt, id_is_load, id_dst};

endmodule
